// File: rtl/uart_prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the UART program loader.
// The loader takes the slave side; whatever feeds it bytes and watches the
// memory/control outputs takes the master side.
interface uart_prog_loader_if #(
    parameter int unsigned ADDR_W = 32
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              loading;
    logic              load_done;
    logic              load_err;

    modport slave (
        input  rx_data,
        input  rx_valid,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output loading,
        output load_done,
        output load_err
    );

    modport master (
        output rx_data,
        output rx_valid,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  loading,
        input  load_done,
        input  load_err
    );
endinterface

// File: rtl/uart_prog_loader.sv
// UART program loader: decodes a length-prefixed frame of little-endian words
// from the UART byte stream, writes each word into instruction memory and keeps
// the core in reset until the whole program has been written.
module uart_prog_loader #(
    parameter int unsigned       ADDR_W         = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
    parameter int unsigned       MAX_WORDS      = 1024,
    parameter int unsigned       TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                clk,
    input  logic                rst,
    uart_prog_loader_if.slave   bus
);

    localparam logic [1:0] S_LEN  = 2'd0;
    localparam logic [1:0] S_WORD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    // The idle counter only ever needs to hold TIMEOUT_CYCLES-1.
    localparam int unsigned      TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]      MAX_LEN  = 32'(MAX_WORDS);

    logic [1:0]        state_q,     state_d;
    logic [1:0]        byte_idx_q,  byte_idx_d;
    logic [31:0]       asm_q,       asm_d;
    logic [31:0]       len_q,       len_d;
    logic [31:0]       word_idx_q,  word_idx_d;
    logic [TMO_W-1:0]  tmo_q,       tmo_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              loading_q,   loading_d;
    logic              load_done_q, load_done_d;
    logic              load_err_q,  load_err_d;

    logic              accept;
    logic              mid_frame;
    logic [31:0]       word_off;

    // Next-state logic: byte assembly, frame decode, word writes and idle timeout.
    always_comb begin
        state_d     = state_q;
        byte_idx_d  = byte_idx_q;
        asm_d       = asm_q;
        len_d       = len_q;
        word_idx_d  = word_idx_q;
        tmo_d       = tmo_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        loading_d   = loading_q;
        load_done_d = 1'b0;
        load_err_d  = load_err_q;
        word_off    = word_idx_q << 2;

        accept    = bus.rx_valid && ((state_q == S_LEN) || (state_q == S_WORD));
        mid_frame = ((state_q == S_LEN) && (byte_idx_q != 2'd0)) || (state_q == S_WORD);

        if (accept) begin
            // Byte k of a group lands in bits [8k+7:8k]; asm_d holds the full group on byte 3.
            asm_d[{byte_idx_q, 3'b000} +: 8] = bus.rx_data;
            byte_idx_d = byte_idx_q + 2'd1;
            tmo_d      = '0;
            if (byte_idx_q == 2'd3) begin
                if (state_q == S_LEN) begin
                    len_d      = asm_d;
                    word_idx_d = '0;
                    if (asm_d == 32'd0) begin
                        // An empty program completes immediately without any write.
                        state_d     = S_DONE;
                        load_done_d = 1'b1;
                        loading_d   = 1'b0;
                    end else if (asm_d > MAX_LEN) begin
                        state_d    = S_ERR;
                        load_err_d = 1'b1;
                    end else begin
                        state_d = S_WORD;
                    end
                end else begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = BASE_ADDR + ADDR_W'(word_off);
                    mem_wdata_d = asm_d;
                    word_idx_d  = word_idx_q + 32'd1;
                    if (word_idx_q == len_q - 32'd1) begin
                        state_d = S_DONE;
                    end
                end
            end
        end else if (mid_frame) begin
            if (tmo_q == TMO_LAST) begin
                // Stalled frame: drop it and wait for a fresh length prefix.
                state_d    = S_LEN;
                byte_idx_d = 2'd0;
                word_idx_d = '0;
                tmo_d      = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end else begin
            tmo_d = '0;
        end

        // First cycle in S_DONE after the final write: pulse done and release the core.
        if ((state_q == S_DONE) && loading_q) begin
            load_done_d = 1'b1;
            loading_d   = 1'b0;
        end
    end

    // State and output registers; reset aborts any frame in progress immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_LEN;
            byte_idx_q  <= 2'd0;
            asm_q       <= '0;
            len_q       <= '0;
            word_idx_q  <= '0;
            tmo_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            loading_q   <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            asm_q       <= asm_d;
            len_q       <= len_d;
            word_idx_q  <= word_idx_d;
            tmo_q       <= tmo_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            loading_q   <= loading_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
        end
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.loading   = loading_q;
    assign bus.load_done = load_done_q;
    assign bus.load_err  = load_err_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed testbench for uart_prog_loader (TIMEOUT_CYCLES shortened to 50).
module tb_uart_prog_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors   = 0;
    int   checks   = 0;
    int   we_count = 0;
    int   we_base  = 0;

    uart_prog_loader_if #(.ADDR_W(32)) bus ();

    uart_prog_loader #(
        .ADDR_W         (32),
        .BASE_ADDR      (32'h0),
        .MAX_WORDS      (1024),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Count every write strobe seen at a clock edge.
    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) we_count++;
    end

    // Hard stop if the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Present one byte for exactly one clock edge; returns at the following negedge.
    task automatic applyStimulus(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
        we_base = we_count;
    endtask

    task automatic expectWrite(input string tag, input logic [31:0] addr, input logic [31:0] data);
        checkOutput({tag, "_we"},   32'(bus.mem_we), 32'd1);
        checkOutput({tag, "_addr"}, bus.mem_addr,    addr);
        checkOutput({tag, "_data"}, bus.mem_wdata,   data);
    endtask

    initial begin
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        @(negedge clk);

        // Reset values
        checkOutput("rst_we",      32'(bus.mem_we),    32'd0);
        checkOutput("rst_addr",    bus.mem_addr,       32'd0);
        checkOutput("rst_wdata",   bus.mem_wdata,      32'd0);
        checkOutput("rst_loading", 32'(bus.loading),   32'd1);
        checkOutput("rst_done",    32'(bus.load_done), 32'd0);
        checkOutput("rst_err",     32'(bus.load_err),  32'd0);

        // Two-word program, bytes back to back (next word starts in the write cycle)
        doReset();
        applyStimulus(8'h02); applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h00);
        checkOutput("t1_len_no_we", 32'(bus.mem_we), 32'd0);
        applyStimulus(8'h13); applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h00);
        expectWrite("t1_w0", 32'h0, 32'h0000_0013);
        checkOutput("t1_w0_loading", 32'(bus.loading), 32'd1);
        applyStimulus(8'h93); applyStimulus(8'h00); applyStimulus(8'h10); applyStimulus(8'h00);
        expectWrite("t1_w1", 32'h4, 32'h0010_0093);
        checkOutput("t1_w1_done", 32'(bus.load_done), 32'd0);
        idle(1);
        checkOutput("t1_done",       32'(bus.load_done), 32'd1);
        checkOutput("t1_loading",    32'(bus.loading),   32'd0);
        checkOutput("t1_we_low",     32'(bus.mem_we),    32'd0);
        checkOutput("t1_addr_hold",  bus.mem_addr,       32'h4);
        checkOutput("t1_wdata_hold", bus.mem_wdata,      32'h0010_0093);
        idle(1);
        checkOutput("t1_done_pulse", 32'(bus.load_done), 32'd0);
        applyStimulus(8'h55);
        idle(2);
        checkOutput("t1_loading_stays", 32'(bus.loading), 32'd0);
        checkOutput("t1_write_count",   32'(we_count - we_base), 32'd2);

        // Empty program
        doReset();
        applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h00);
        checkOutput("t2_done",    32'(bus.load_done), 32'd1);
        checkOutput("t2_loading", 32'(bus.loading),   32'd0);
        idle(1);
        checkOutput("t2_done_pulse", 32'(bus.load_done), 32'd0);
        applyStimulus(8'hAA); applyStimulus(8'hBB);
        idle(3);
        checkOutput("t2_no_writes", 32'(we_count - we_base), 32'd0);
        checkOutput("t2_no_redone", 32'(bus.load_done),      32'd0);

        // Oversized length (1025 words)
        doReset();
        applyStimulus(8'h01); applyStimulus(8'h04); applyStimulus(8'h00);
        checkOutput("t3_err_early", 32'(bus.load_err), 32'd0);
        applyStimulus(8'h00);
        checkOutput("t3_err",     32'(bus.load_err), 32'd1);
        checkOutput("t3_loading", 32'(bus.loading),  32'd1);
        for (int i = 0; i < 8; i++) applyStimulus(8'(8'h30 + i));
        idle(2);
        checkOutput("t3_err_sticky", 32'(bus.load_err),      32'd1);
        checkOutput("t3_loading2",   32'(bus.loading),       32'd1);
        checkOutput("t3_no_writes",  32'(we_count - we_base), 32'd0);
        checkOutput("t3_no_done",    32'(bus.load_done),     32'd0);

        // Idle timeout discards a partial frame
        doReset();
        applyStimulus(8'h01); applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h00);
        applyStimulus(8'hEF); applyStimulus(8'hBE);
        idle(50);
        checkOutput("t4_no_write", 32'(we_count - we_base), 32'd0);
        checkOutput("t4_loading",  32'(bus.loading),        32'd1);
        applyStimulus(8'h01); applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h00);
        applyStimulus(8'hEF); applyStimulus(8'hBE); applyStimulus(8'hAD); applyStimulus(8'hDE);
        expectWrite("t4_w0", 32'h0, 32'hDEAD_BEEF);
        idle(1);
        checkOutput("t4_done", 32'(bus.load_done), 32'd1);
        idle(2);
        checkOutput("t4_write_count", 32'(we_count - we_base), 32'd1);

        // Byte arriving in the same cycle the timeout would expire is kept
        doReset();
        applyStimulus(8'h01); applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h00);
        applyStimulus(8'hEF); applyStimulus(8'hBE);
        idle(49);
        applyStimulus(8'hAD);
        idle(49);
        applyStimulus(8'hDE);
        expectWrite("t5_w0", 32'h0, 32'hDEAD_BEEF);
        idle(1);
        checkOutput("t5_done", 32'(bus.load_done), 32'd1);

        // Asynchronous reset in the middle of a word
        doReset();
        applyStimulus(8'h02); applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h00);
        applyStimulus(8'h78); applyStimulus(8'h56); applyStimulus(8'h34); applyStimulus(8'h12);
        expectWrite("t6_w0", 32'h0, 32'h1234_5678);
        applyStimulus(8'h11); applyStimulus(8'h22);
        we_base = we_count;
        #2 rst = 1'b1;
        #1;
        checkOutput("t6_async_we",      32'(bus.mem_we),    32'd0);
        checkOutput("t6_async_addr",    bus.mem_addr,       32'd0);
        checkOutput("t6_async_wdata",   bus.mem_wdata,      32'd0);
        checkOutput("t6_async_loading", 32'(bus.loading),   32'd1);
        checkOutput("t6_async_done",    32'(bus.load_done), 32'd0);
        idle(3);
        rst = 1'b0;
        idle(1);
        checkOutput("t6_no_partial_write", 32'(we_count - we_base), 32'd0);
        applyStimulus(8'h01); applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h00);
        applyStimulus(8'h44); applyStimulus(8'h33); applyStimulus(8'h22); applyStimulus(8'h11);
        expectWrite("t6_w0_after", 32'h0, 32'h1122_3344);
        idle(1);
        checkOutput("t6_done",    32'(bus.load_done), 32'd1);
        checkOutput("t6_loading", 32'(bus.loading),   32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
